// File: rtl/counter_reload_pkg.sv
// Shared types and helpers for the preset reload queue.
package counter_reload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RUN     = 2'd2,
    ST_STARVED = 2'd3
  } state_e;

  // Width of an occupancy count able to represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reload_fifo.sv
// Synchronous FIFO with combinational head read; storage is not reset.
module reload_fifo
  import counter_reload_pkg::*;
#(
  parameter int unsigned Bits  = 4,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = level_width(Depth)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [Bits-1:0] push_data,
  output logic [Bits-1:0] head,
  output logic [LvlW-1:0] level,
  output logic            empty,
  output logic            full
);

  logic [Bits-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign empty = (level_q == '0);
  assign full  = (level_q == LvlW'(Depth));

endmodule

// File: rtl/counter_reload_queue.sv
// Queues preset values and loads the next one into a preset counter at terminal count.
module counter_reload_queue
  import counter_reload_pkg::*;
#(
  parameter int unsigned Bits  = 4,
  parameter int unsigned Depth = 4,
  localparam int unsigned LvlW = level_width(Depth)
) (
  input  logic            C,
  input  logic            nRst,
  input  logic            start,
  input  logic            stop,
  input  logic            recycle,
  input  logic [Bits-1:0] wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic            ovf,
  output logic            ld,
  output logic [Bits-1:0] in,
  output logic            empty,
  output logic            full,
  output logic [LvlW-1:0] level,
  output logic            underrun,
  input  logic            clr_err
);

  state_e          state_q, state_d;
  logic            underrun_q, underrun_d;
  logic            fifo_push;
  logic [Bits-1:0] fifo_push_data;
  logic [Bits-1:0] head;

  reload_fifo #(.Bits(Bits), .Depth(Depth)) u_fifo (
    .clk       (C),
    .rst_n     (nRst),
    .push      (fifo_push),
    .pop       (ld),
    .push_data (fifo_push_data),
    .head      (head),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  // Sequencer: ld is decided combinationally so a load lands on the wrap edge itself.
  always_comb begin
    state_d    = state_q;
    ld         = 1'b0;
    underrun_d = underrun_q & ~clr_err;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM, ST_STARVED: begin
        ld = ~empty;
        if (!empty) state_d = ST_RUN;
      end
      ST_RUN: begin
        ld = ovf & ~empty;
        if (ovf && empty) begin
          state_d    = ST_STARVED;
          underrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      ld      = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge C or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      underrun_q <= underrun_d;
    end
  end

  // In recycle mode every pop re-appends the popped head at the tail.
  assign wr_ready       = ~full & ~recycle;
  assign fifo_push      = (wr_valid & wr_ready) | (recycle & ld);
  assign fifo_push_data = (recycle && ld) ? head : wr_data;

  assign in       = empty ? '0 : head;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_counter_reload_queue.sv
// Directed and randomized checks of counter_reload_queue against a queue-based model.
module tb_counter_reload_queue;

  localparam int unsigned BITS  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVLW  = $clog2(DEPTH) + 1;

  logic            C = 1'b0;
  logic            nRst, start, stop, recycle, wr_valid, ovf, clr_err;
  logic [BITS-1:0] wr_data;
  logic            wr_ready, ld, empty, full, underrun;
  logic [BITS-1:0] in;
  logic [LVLW-1:0] level;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: stored presets in arrival order, a mode (0 idle, 1 armed, 2 running, 3 starved).
  int q_m[$];
  int st_m = 0;
  bit ur_m = 1'b0;

  counter_reload_queue #(.Bits(BITS), .Depth(DEPTH)) dut (
    .C        (C),
    .nRst     (nRst),
    .start    (start),
    .stop     (stop),
    .recycle  (recycle),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .ovf      (ovf),
    .ld       (ld),
    .in       (in),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .underrun (underrun),
    .clr_err  (clr_err)
  );

  always #5 C = ~C;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit exp_ld();
    bit e;
    e = (q_m.size() == 0);
    if (stop) return 1'b0;
    case (st_m)
      1, 3:    return !e;
      2:       return ovf && !e;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge C or negedge nRst) begin
    if (!nRst) begin
      q_m.delete();
      st_m = 0;
      ur_m = 1'b0;
    end else begin
      bit l, e, p;
      int hv;
      e = (q_m.size() == 0);
      l = exp_ld();
      p = wr_valid && (q_m.size() != DEPTH) && !recycle;
      if (st_m == 2 && ovf && e) ur_m = 1'b1;
      else if (clr_err)          ur_m = 1'b0;
      if (l) begin
        hv = q_m.pop_front();
        if (recycle) q_m.push_back(hv);
      end
      if (p) q_m.push_back(int'(wr_data));
      if (stop) st_m = 0;
      else case (st_m)
        0:       if (start) st_m = 1;
        1, 3:    if (l) st_m = 2;
        2:       if (ovf && e) st_m = 3;
        default: st_m = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge C) begin
    int sz;
    sz = q_m.size();
    chk("ld",       int'(ld),       int'(exp_ld()));
    chk("in",       int'(in),       (sz == 0) ? 0 : q_m[0]);
    chk("empty",    int'(empty),    int'(sz == 0));
    chk("full",     int'(full),     int'(sz == DEPTH));
    chk("level",    int'(level),    sz);
    chk("wr_ready", int'(wr_ready), int'((sz != DEPTH) && !recycle));
    chk("underrun", int'(underrun), int'(ur_m));
  end

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  initial begin
    int seq[4];
    seq = '{2, 4, 2, 4};
    nRst = 1'b0; start = 1'b0; stop = 1'b0; recycle = 1'b0;
    wr_valid = 1'b1; wr_data = 4'd5; ovf = 1'b0; clr_err = 1'b0;
    tick();
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_ld", int'(ld), 0);
    chk("rst_in", int'(in), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);

    nRst = 1'b1;
    tick();
    wr_data = 4'd9; tick();
    wr_data = 4'd3; tick();
    wr_valid = 1'b0; #1;
    chk("fill3_level", int'(level), 3);
    chk("fill3_in", int'(in), 5);
    chk("idle_ld", int'(ld), 0);

    start = 1'b1; tick(); start = 1'b0; #1;
    chk("arm_ld", int'(ld), 1);
    chk("arm_in", int'(in), 5);
    tick();
    chk("run_level", int'(level), 2);
    chk("run_in", int'(in), 9);
    chk("run_ld_idle", int'(ld), 0);

    ovf = 1'b1; #1;
    chk("ovf_ld", int'(ld), 1);
    chk("ovf_in", int'(in), 9);
    tick(); ovf = 1'b0; #1;
    chk("after_pop_level", int'(level), 1);
    chk("after_pop_in", int'(in), 3);
    chk("after_pop_ld", int'(ld), 0);

    ovf = 1'b1; #1;
    chk("last_ld", int'(ld), 1);
    tick(); ovf = 1'b0; #1;
    chk("drained_empty", int'(empty), 1);
    tick();
    ovf = 1'b1; #1;
    chk("starve_ld", int'(ld), 0);
    tick(); ovf = 1'b0; #1;
    chk("underrun_set", int'(underrun), 1);
    wr_valid = 1'b1; wr_data = 4'd7;
    tick(); wr_valid = 1'b0; #1;
    chk("starved_ld", int'(ld), 1);
    chk("starved_in", int'(in), 7);
    tick();
    chk("resumed_ld", int'(ld), 0);
    chk("resumed_level", int'(level), 0);
    chk("underrun_sticky", int'(underrun), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0; #1;
    chk("underrun_clr", int'(underrun), 0);

    wr_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 4'(i);
      tick();
    end
    chk("full_flag", int'(full), 1);
    chk("full_wr_ready", int'(wr_ready), 0);
    chk("full_level", int'(level), 4);
    wr_data = 4'd6; tick(); wr_valid = 1'b0; #1;
    chk("full_ignore", int'(level), 4);
    ovf = 1'b1; tick();
    wr_valid = 1'b1; wr_data = 4'd8; tick();
    ovf = 1'b0; wr_valid = 1'b0; #1;
    chk("pushpop_level", int'(level), 3);
    chk("pushpop_in", int'(in), 3);

    nRst = 1'b0; #1;
    chk("rst_level2", int'(level), 0);
    tick(); nRst = 1'b1;
    wr_valid = 1'b1; wr_data = 4'd2; tick();
    wr_data = 4'd4; tick();
    wr_valid = 1'b0; recycle = 1'b1; #1;
    chk("rcy_wr_ready", int'(wr_ready), 0);
    chk("rcy_level", int'(level), 2);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) ovf = 1'b1;
      #1;
      chk("rcy_ld", int'(ld), 1);
      chk("rcy_in", int'(in), seq[k]);
      tick(); ovf = 1'b0; #1;
      chk("rcy_level_hold", int'(level), 2);
    end
    ovf = 1'b1; stop = 1'b1; #1;
    chk("stop_ld", int'(ld), 0);
    tick(); stop = 1'b0; #1;
    chk("stopped_ld", int'(ld), 0);
    chk("stopped_level", int'(level), 2);
    ovf = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ovf = 1'b1; #1;
    chk("prerst_ld", int'(ld), 1);
    #2 nRst = 1'b0; #1;
    chk("async_rst_ld", int'(ld), 0);
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_in", int'(in), 0);
    ovf = 1'b0;
    tick(); nRst = 1'b1; recycle = 1'b0;

    for (int n = 0; n < 4000; n++) begin
      nRst     = ($urandom_range(0, 799) != 0);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) recycle = ~recycle;
      wr_valid = $urandom_range(0, 1) == 1;
      wr_data  = 4'($urandom);
      ovf      = ($urandom_range(0, 3) == 0);
      clr_err  = ($urandom_range(0, 15) == 0);
      tick();
    end
    @(negedge C);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
